fifo_rd_ctrl: RTL and testbench

Read-domain controller for the asynchronous FIFO; the counterpart of the write-pointer block. It synchronises the write-domain gray pointer into rd_clk and maintains the read binary address and gray pointer. It generates empty, almost-empty and fill-level status, plus read-valid and read-error strobes for the synchronous dual-port RAM. Its rd_ptr output feeds the write domain's read-pointer synchroniser.

---
 rtl/fifo_rd_ctrl_pkg.sv | 30 +++
 rtl/fifo_sync_ptr.sv | 25 ++
 rtl/fifo_rd_ctrl.sv | 80 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the async FIFO pointer blocks: default address width,
// gray/binary conversion helpers and the read-side flag bundle.
package fifo_rd_ctrl_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;

    typedef struct packed {
        logic empty;
        logic aempty;
        logic valid;
        logic err;
    } rd_flags_t;

    localparam rd_flags_t RD_FLAGS_RST = '{empty: 1'b1, aempty: 1'b1, valid: 1'b0, err: 1'b0};

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB; zero-extended upper bits leave narrow values intact.
    function automatic logic [31:0] gray2bin(input logic [31:0] gry);
        logic [31:0] bin;
        bin[31] = gry[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gry[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Multi-flop synchroniser for a gray-coded FIFO pointer crossing into clk.
// Also used on the write side for the read pointer.
module fifo_sync_ptr #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, synchronised write
// pointer, and pessimistic empty / almost-empty / level status.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic                  rd_empty,
    output logic                  rd_aempty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_valid,
    output logic                  rd_err
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] rd_bin_reg, rd_bin_next;
    logic [PTR_W-1:0] rd_gry_reg, rd_gry_next;
    logic [PTR_W-1:0] level_reg, level_next;
    logic [PTR_W-1:0] w2r_ptr, w2r_bin;
    rd_flags_t        flags_reg, flags_next;
    logic             rd_acc;

    fifo_sync_ptr #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_w2r_sync (
        .clk   (rd_clk),
        .rst_n (rd_rst),
        .d     (wr_ptr),
        .q     (w2r_ptr)
    );

    // Acceptance uses the registered empty, so a read never overtakes the flag.
    assign rd_acc = rd_en && !flags_reg.empty;

    always_comb begin
        rd_bin_next       = rd_bin_reg + {{(PTR_W-1){1'b0}}, rd_acc};
        rd_gry_next       = PTR_W'(bin2gray(32'(rd_bin_next)));
        w2r_bin           = PTR_W'(gray2bin(32'(w2r_ptr)));
        level_next        = w2r_bin - rd_bin_next;
        flags_next        = RD_FLAGS_RST;
        flags_next.empty  = (rd_gry_next == w2r_ptr);
        flags_next.aempty = (level_next <= AEMPTY_LVL);
        flags_next.valid  = rd_acc;
        flags_next.err    = rd_en && flags_reg.empty;
    end

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            rd_bin_reg <= '0;
            rd_gry_reg <= '0;
            level_reg  <= '0;
            flags_reg  <= RD_FLAGS_RST;
        end else begin
            rd_bin_reg <= rd_bin_next;
            rd_gry_reg <= rd_gry_next;
            level_reg  <= level_next;
            flags_reg  <= flags_next;
        end
    end

    assign rd_addr   = rd_bin_reg[ADDR_WIDTH-1:0];
    assign rd_ptr    = rd_gry_reg;
    assign rd_level  = level_reg;
    assign rd_empty  = flags_reg.empty;
    assign rd_aempty = flags_reg.aempty;
    assign rd_valid  = flags_reg.valid;
    assign rd_err    = flags_reg.err;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl at default parameters (depth 16, 2-stage sync).
module tb_fifo_rd_ctrl;

    logic       rd_clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rd_rst = 1'b1;
    logic       rd_en = 1'b0;
    logic [4:0] wr_ptr = 5'h00;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr;
    logic       rd_empty;
    logic       rd_aempty;
    logic [4:0] rd_level;
    logic       rd_valid;
    logic       rd_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    fifo_rd_ctrl dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .rd_en     (rd_en),
        .wr_ptr    (wr_ptr),
        .rd_addr   (rd_addr),
        .rd_ptr    (rd_ptr),
        .rd_empty  (rd_empty),
        .rd_aempty (rd_aempty),
        .rd_level  (rd_level),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err)
    );

    always begin
        #5;
        if (clk_run) rd_clk = ~rd_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int addr, input int ptr, input int empty,
                           input int aempty, input int level, input int valid, input int err);
        chk({tag, ".addr"},   32'(rd_addr),   32'(addr));
        chk({tag, ".ptr"},    32'(rd_ptr),    32'(ptr));
        chk({tag, ".empty"},  32'(rd_empty),  32'(empty));
        chk({tag, ".aempty"}, 32'(rd_aempty), 32'(aempty));
        chk({tag, ".level"},  32'(rd_level),  32'(level));
        chk({tag, ".valid"},  32'(rd_valid),  32'(valid));
        chk({tag, ".err"},    32'(rd_err),    32'(err));
    endtask

    // Advance one edge, then sample 1 time unit later; one line per cycle.
    task automatic step();
        @(posedge rd_clk);
        #1;
        cyc++;
        $display("cyc %0d en=%b wr_ptr=%h addr=%0d ptr=%h lvl=%0d empty=%b aempty=%b valid=%b err=%b",
                 cyc, rd_en, wr_ptr, rd_addr, rd_ptr, rd_level, rd_empty, rd_aempty, rd_valid, rd_err);
    endtask

    function automatic logic [4:0] gry(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    initial begin
        logic [4:0] prev_ptr;

        // 1. Reset without any clock
        #2 rd_rst = 1'b0;
        #10;
        chk_all("rst", 0, 0, 1, 1, 0, 0, 0);
        rd_rst = 1'b1;
        #3;
        chk_all("rst_rel", 0, 0, 1, 1, 0, 0, 0);

        // 2. Three words appear; visible only on the third edge
        wr_ptr = 5'h02;
        clk_run = 1'b1;
        step();
        chk("wr_lat1.empty", 32'(rd_empty), 32'd1);
        chk("wr_lat1.level", 32'(rd_level), 32'd0);
        step();
        chk("wr_lat2.empty", 32'(rd_empty), 32'd1);
        chk("wr_lat2.level", 32'(rd_level), 32'd0);
        step();
        chk_all("wr_lat3", 0, 0, 0, 0, 3, 0, 0);

        // 3. Drain three words
        rd_en = 1'b1;
        step();
        chk_all("rd1", 1, gry(1), 0, 1, 2, 1, 0);
        step();
        chk_all("rd2", 2, gry(2), 0, 1, 1, 1, 0);
        step();
        chk_all("rd3", 3, 5'h02, 1, 1, 0, 1, 0);

        // 4. Underflow attempts
        step();
        chk_all("uf1", 3, 5'h02, 1, 1, 0, 0, 1);
        step();
        chk_all("uf2", 3, 5'h02, 1, 1, 0, 0, 1);
        rd_en = 1'b0;
        step();
        chk_all("uf_end", 3, 5'h02, 1, 1, 0, 0, 0);

        // 5. Wrap-around, starting from rd_bin=0 after a reset
        rd_rst = 1'b0;
        wr_ptr = 5'h00;
        #2 rd_rst = 1'b1;
        chk_all("rst2", 0, 0, 1, 1, 0, 0, 0);
        wr_ptr = 5'h18;
        step();
        step();
        chk("full_lat2.empty", 32'(rd_empty), 32'd1);
        step();
        chk_all("full", 0, 0, 0, 0, 16, 0, 0);
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            prev_ptr = rd_ptr;
            step();
            chk($sformatf("wrapA%0d.addr", i), 32'(rd_addr), 32'(i % 16));
            chk($sformatf("wrapA%0d.level", i), 32'(rd_level), 32'(16 - i));
            chk($sformatf("wrapA%0d.onebit", i), 32'($countones(prev_ptr ^ rd_ptr)), 32'd1);
        end
        rd_en = 1'b0;
        chk_all("wrapA_end", 0, 5'h18, 1, 1, 0, 1, 0);

        wr_ptr = 5'h00;
        step();
        step();
        step();
        chk_all("full2", 0, 5'h18, 0, 0, 16, 0, 0);
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            prev_ptr = rd_ptr;
            step();
            chk($sformatf("wrapB%0d.ptr", i), 32'(rd_ptr), 32'(gry(16 + i)));
            chk($sformatf("wrapB%0d.level", i), 32'(rd_level), 32'(16 - i));
            chk($sformatf("wrapB%0d.onebit", i), 32'($countones(prev_ptr ^ rd_ptr)), 32'd1);
        end
        rd_en = 1'b0;
        chk_all("wrapB_end", 0, 5'h00, 1, 1, 0, 1, 0);

        // 6. Asynchronous reset mid-burst
        wr_ptr = 5'h02;
        step();
        step();
        step();
        chk_all("pre_burst", 0, 0, 0, 0, 3, 0, 0);
        rd_en = 1'b1;
        step();
        chk_all("burst1", 1, gry(1), 0, 1, 2, 1, 0);
        #2 rd_rst = 1'b0;
        #1;
        chk_all("arst", 0, 0, 1, 1, 0, 0, 0);
        rd_en = 1'b0;
        #1 rd_rst = 1'b1;
        step();
        chk("post1.empty", 32'(rd_empty), 32'd1);
        step();
        chk("post2.empty", 32'(rd_empty), 32'd1);
        step();
        chk_all("post3", 0, 0, 0, 0, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
